// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elevator_ctrl
// Purpose  : Four-floor elevator controller. Latches floor calls, schedules
//            travel with a direction-preserving (collective) policy, and
//            times floor-to-floor movement and door-open intervals.
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous active-low reset
//            call[3:0] - per-floor call request, level-sampled every cycle
//            door_hold - keeps the door open (only with ELEV_DOOR_HOLD_EN)
//            floor     - current floor 0..3 (registered)
//            state     - 0 IDLE, 1 UP, 2 DOWN, 3 DOOR (registered)
//            pending   - latched outstanding requests (registered)
// Config   : define ELEV_DOOR_HOLD_EN to add the door_hold input.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_ctrl #(
    parameter int MOVE_TICKS = 50_000_000,
    parameter int DOOR_TICKS = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] call,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic       door_hold,
`endif
    output logic [1:0] floor,
    output logic [1:0] state,
    output logic [3:0] pending
);

    localparam int c_MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int c_TW        = $clog2(c_MAX_TICKS);
    localparam logic [c_TW-1:0] c_MOVE_LAST = c_TW'(MOVE_TICKS - 1);
    localparam logic [c_TW-1:0] c_DOOR_LAST = c_TW'(DOOR_TICKS - 1);
    localparam logic            c_DIR_UP    = 1'b1;
    localparam logic            c_DIR_DOWN  = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DOOR = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_TW-1:0]   r_timer;
    logic [c_TW-1:0]   w_timer_next;
    logic              r_dir;
    logic              w_dir_next;
    logic [1:0]        w_floor_next;
    logic [1:0]        w_floor_up;
    logic [1:0]        w_floor_dn;
    logic [3:0]        w_above_mask;
    logic [3:0]        w_below_mask;
    logic              w_above;
    logic              w_below;
    logic              w_here;
    logic              w_hold;
    logic              w_recall;
    logic [3:0]        w_clr;
    logic [3:0]        w_pending_next;

`ifdef ELEV_DOOR_HOLD_EN
    assign w_hold = door_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Scheduling looks only at latched requests, never at raw call inputs.
    assign w_above_mask = 4'b1110 << floor;
    assign w_below_mask = ~(4'b1111 << floor);
    assign w_above      = |(pending & w_above_mask);
    assign w_below      = |(pending & w_below_mask);
    assign w_here       = pending[floor];
    assign w_recall     = call[floor];

    // Saturating neighbours guard against ever leaving 0..3.
    assign w_floor_up   = (floor == 2'd3) ? 2'd3 : floor + 2'd1;
    assign w_floor_dn   = (floor == 2'd0) ? 2'd0 : floor - 2'd1;

    always_comb begin
        w_state_next = r_state;
        w_floor_next = floor;
        w_dir_next   = r_dir;
        w_timer_next = r_timer + c_TW'(1);
        case (r_state)
            S_IDLE: begin
                w_timer_next = '0;
                if (w_here) begin
                    w_state_next = S_DOOR;
                end else if (w_above) begin
                    w_state_next = S_UP;
                    w_dir_next   = c_DIR_UP;
                end else if (w_below) begin
                    w_state_next = S_DOWN;
                    w_dir_next   = c_DIR_DOWN;
                end
            end
            S_UP: begin
                if (r_timer == c_MOVE_LAST) begin
                    w_timer_next = '0;
                    w_floor_next = w_floor_up;
                    if (pending[w_floor_up]) begin
                        w_state_next = S_DOOR;
                    end
                end
            end
            S_DOWN: begin
                if (r_timer == c_MOVE_LAST) begin
                    w_timer_next = '0;
                    w_floor_next = w_floor_dn;
                    if (pending[w_floor_dn]) begin
                        w_state_next = S_DOOR;
                    end
                end
            end
            S_DOOR: begin
                // A re-call of this floor or an active hold restarts the interval.
                if (w_recall || w_hold) begin
                    w_timer_next = '0;
                end else if (r_timer == c_DOOR_LAST) begin
                    w_timer_next = '0;
                    if (r_dir == c_DIR_UP && w_above) begin
                        w_state_next = S_UP;
                    end else if (r_dir == c_DIR_DOWN && w_below) begin
                        w_state_next = S_DOWN;
                    end else if (w_below) begin
                        w_state_next = S_DOWN;
                        w_dir_next   = c_DIR_DOWN;
                    end else if (w_above) begin
                        w_state_next = S_UP;
                        w_dir_next   = c_DIR_UP;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    // The door floor's bit is cleared on the edge DOOR is entered (using the
    // floor being arrived at) and masked for as long as the door stays open.
    assign w_clr          = (r_state == S_DOOR || w_state_next == S_DOOR)
                            ? (4'b0001 << w_floor_next) : 4'b0000;
    assign w_pending_next = (pending | call) & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_dir   <= c_DIR_UP;
            floor   <= 2'd0;
            pending <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_dir   <= w_dir_next;
            floor   <= w_floor_next;
            pending <= w_pending_next;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_ctrl
// Purpose  : Directed self-checking bench for elevator_ctrl with
//            MOVE_TICKS=4, DOOR_TICKS=3. Door-hold scenario is compiled in
//            only when ELEV_DOOR_HOLD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_ctrl;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DOOR = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [3:0] call;
    logic       door_hold;
    logic [1:0] floor;
    logic [1:0] state;
    logic [3:0] pending;

    int n_assert = 0;
    int n_fail   = 0;

    elevator_ctrl #(
        .MOVE_TICKS(4),
        .DOOR_TICKS(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .call     (call),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .floor    (floor),
        .state    (state),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit before sampling/driving.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic [1:0] fl, input logic [3:0] pd);
        chk({tag, ".state"},   {2'b00, state}, {2'b00, st});
        chk({tag, ".floor"},   {2'b00, floor}, {2'b00, fl});
        chk({tag, ".pending"}, pending,        pd);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        call      = 4'b0000;
        door_hold = 1'b0;
        tick(2);
        chk_all("reset", ST_IDLE, 2'd0, 4'b0000);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        call      = 4'b0000;
        door_hold = 1'b0;

        // Single call to floor 2 from floor 0.
        reset_dut();
        call = 4'b0100; tick(1); call = 4'b0000;
        chk_all("s1_e0",  ST_IDLE, 2'd0, 4'b0100);
        tick(1); chk_all("s1_e1",  ST_UP,   2'd0, 4'b0100);
        tick(3); chk_all("s1_e4",  ST_UP,   2'd0, 4'b0100);
        tick(1); chk_all("s1_e5",  ST_UP,   2'd1, 4'b0100);
        tick(3); chk_all("s1_e8",  ST_UP,   2'd1, 4'b0100);
        tick(1); chk_all("s1_e9",  ST_DOOR, 2'd2, 4'b0000);
        tick(2); chk_all("s1_e11", ST_DOOR, 2'd2, 4'b0000);
        tick(1); chk_all("s1_e12", ST_IDLE, 2'd2, 4'b0000);

        // Call at the current floor opens the door directly.
        reset_dut();
        call = 4'b0001; tick(1); call = 4'b0000;
        chk_all("s2_e0", ST_IDLE, 2'd0, 4'b0001);
        tick(1); chk_all("s2_e1", ST_DOOR, 2'd0, 4'b0000);
        tick(2); chk_all("s2_e3", ST_DOOR, 2'd0, 4'b0000);
        tick(1); chk_all("s2_e4", ST_IDLE, 2'd0, 4'b0000);

        // Call to 3, intermediate call to 1 while travelling.
        reset_dut();
        call = 4'b1000; tick(1); call = 4'b0000;
        tick(1); chk_all("s3_e1", ST_UP, 2'd0, 4'b1000);
        tick(1);
        call = 4'b0010; tick(1); call = 4'b0000;
        chk_all("s3_e3",  ST_UP,   2'd0, 4'b1010);
        tick(2); chk_all("s3_e5",  ST_DOOR, 2'd1, 4'b1000);
        tick(2); chk_all("s3_e7",  ST_DOOR, 2'd1, 4'b1000);
        tick(1); chk_all("s3_e8",  ST_UP,   2'd1, 4'b1000);
        tick(4); chk_all("s3_e12", ST_UP,   2'd2, 4'b1000);
        tick(4); chk_all("s3_e16", ST_DOOR, 2'd3, 4'b0000);
        tick(3); chk_all("s3_e19", ST_IDLE, 2'd3, 4'b0000);

        // At floor 2 door open going up, calls on 3 and 0: serve 3, then reverse.
        reset_dut();
        call = 4'b0100; tick(1); call = 4'b0000;
        tick(9); chk_all("s4_e9", ST_DOOR, 2'd2, 4'b0000);
        call = 4'b1001; tick(1); call = 4'b0000;
        chk_all("s4_e10", ST_DOOR, 2'd2, 4'b1001);
        tick(2); chk_all("s4_e12", ST_UP,   2'd2, 4'b1001);
        tick(3); chk_all("s4_e15", ST_UP,   2'd2, 4'b1001);
        tick(1); chk_all("s4_e16", ST_DOOR, 2'd3, 4'b0001);
        tick(3); chk_all("s4_e19", ST_DOWN, 2'd3, 4'b0001);
        tick(4); chk_all("s4_e23", ST_DOWN, 2'd2, 4'b0001);
        tick(4); chk_all("s4_e27", ST_DOWN, 2'd1, 4'b0001);
        tick(4); chk_all("s4_e31", ST_DOOR, 2'd0, 4'b0000);
        tick(3); chk_all("s4_e34", ST_IDLE, 2'd0, 4'b0000);

        // Re-call of the open floor at timer=2 extends DOOR by 3 cycles.
        reset_dut();
        call = 4'b0001; tick(1); call = 4'b0000;
        tick(3); chk_all("s5_e3", ST_DOOR, 2'd0, 4'b0000);
        call = 4'b0001; tick(1); call = 4'b0000;
        chk_all("s5_e4", ST_DOOR, 2'd0, 4'b0000);
        tick(2); chk_all("s5_e6", ST_DOOR, 2'd0, 4'b0000);
        tick(1); chk_all("s5_e7", ST_IDLE, 2'd0, 4'b0000);

        // Asynchronous reset in the middle of upward travel.
        call = 4'b1000; tick(1); call = 4'b0000;
        tick(6); chk_all("s5_mid", ST_UP, 2'd1, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk_all("s5_async_rst", ST_IDLE, 2'd0, 4'b0000);
        tick(1);
        rst_n = 1'b1;

`ifdef ELEV_DOOR_HOLD_EN
        // Door hold for 10 cycles, then exactly 3 more cycles of DOOR.
        reset_dut();
        call = 4'b0001; tick(1); call = 4'b0000;
        tick(1); chk_all("s6_e1", ST_DOOR, 2'd0, 4'b0000);
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("s6_hold.state", {2'b00, state}, {2'b00, ST_DOOR});
        end
        door_hold = 1'b0;
        tick(2); chk_all("s6_rel2", ST_DOOR, 2'd0, 4'b0000);
        tick(1); chk_all("s6_rel3", ST_IDLE, 2'd0, 4'b0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
